// File: rtl/diff_decode_rx.sv
// Framed serial receiver: optional NRZI-style differential decode, sync hunt with
// flywheel lock, and a one-entry output stage. Macro DIFF_DECODE_RX_NRZI_EN enables the decode.
module diff_decode_rx #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned MISS_MAX  = 2
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       din,
  input  logic       din_valid,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       locked,
  output logic       overrun
);

  // Output handshake: a byte is transferred on any rising edge where
  // dout_valid=1 and dout_ready=1; dout/dout_valid hold until then.

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [7:0] FRAME_LAST = 8'(FRAME_LEN - 1);
  localparam logic [3:0] MISS_LAST  = 4'(MISS_MAX - 1);

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [3:0] miss_cnt_q, miss_cnt_d;
  // Seven bits of history suffice: the oldest bit of the 8-bit window is never read again.
  logic [6:0] shift_q, shift_d;
  logic [7:0] shift_nxt;
  logic [7:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       overrun_q, overrun_d;
  logic       bit_dec;
  logic       byte_done;

`ifdef DIFF_DECODE_RX_NRZI_EN
  logic prev_q;

  assign bit_dec = din ^ prev_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      prev_q <= 1'b0;
    end else if (din_valid) begin
      prev_q <= din;
    end
  end
`else
  assign bit_dec = din;
`endif

  assign shift_nxt = {shift_q, bit_dec};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    miss_cnt_d = miss_cnt_q;
    shift_d    = shift_q;
    byte_done  = 1'b0;
    if (din_valid) begin
      shift_d = shift_nxt[6:0];
      case (state_q)
        HUNT: begin
          if (shift_nxt == SYNC_BYTE) begin
            state_d    = DATA;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 8'd0;
          end
        end
        DATA: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_done = 1'b1;
            if (byte_cnt_q == FRAME_LAST) begin
              byte_cnt_d = 8'd0;
              state_d    = CHECK;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
          end
        end
        CHECK: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shift_nxt == SYNC_BYTE) begin
              miss_cnt_d = 4'd0;
              state_d    = DATA;
            end else if (miss_cnt_q == MISS_LAST) begin
              miss_cnt_d = 4'd0;
              state_d    = HUNT;
            end else begin
              miss_cnt_d = miss_cnt_q + 4'd1;
              state_d    = DATA;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Output stage is deliberately decoupled from lock state.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = 1'b0;
    if (byte_done) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = shift_nxt;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= HUNT;
      bit_cnt_q    <= 3'd0;
      byte_cnt_q   <= 8'd0;
      miss_cnt_q   <= 4'd0;
      shift_q      <= 7'd0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;
  assign locked     = (state_q != HUNT);

endmodule

// File: tb/tb_diff_decode_rx.sv
// Bench for diff_decode_rx: random and directed bit streams checked against a
// bit-level framing model and a byte scoreboard.
module tb_diff_decode_rx;

  localparam logic [7:0] SYNC      = 8'hA5;
  localparam int         FRAME_LEN = 4;
  localparam int         MISS_MAX  = 2;

  logic       clk;
  logic       resetb;
  logic       din;
  logic       din_valid;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       locked;
  logic       overrun;

  diff_decode_rx #(
    .SYNC_BYTE(SYNC),
    .FRAME_LEN(FRAME_LEN),
    .MISS_MAX (MISS_MAX)
  ) dut (
    .clk       (clk),
    .resetb    (resetb),
    .din       (din),
    .din_valid (din_valid),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .locked    (locked),
    .overrun   (overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         err_cnt = 0;
  int         chk_cnt = 0;
  logic [7:0] exp_q[$];
  int         rx_cnt = 0;
  int         ovr_cnt = 0;

  // reference model state (framing rules on decoded bits)
  int         m_mode;   // 0 hunting, 1 payload, 2 sync check
  int         m_cnt;
  int         m_bytes;
  int         m_miss;
  logic [7:0] m_win;
  bit         push_en = 1'b1;
  logic       enc_prev;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_cnt   = 0;
    m_bytes = 0;
    m_miss  = 0;
    m_win   = 8'h00;
  endtask

  task automatic model_step(input logic b);
    m_win = {m_win[6:0], b};
    if (m_mode == 0) begin
      if (m_win == SYNC) begin
        m_mode  = 1;
        m_cnt   = 0;
        m_bytes = 0;
      end
    end else begin
      m_cnt = m_cnt + 1;
      if (m_cnt == 8) begin
        m_cnt = 0;
        if (m_mode == 1) begin
          if (push_en) exp_q.push_back(m_win);
          m_bytes = m_bytes + 1;
          if (m_bytes == FRAME_LEN) begin
            m_bytes = 0;
            m_mode  = 2;
          end
        end else begin
          m_miss = (m_win == SYNC) ? 0 : m_miss + 1;
          if (m_miss == MISS_MAX) begin
            m_miss = 0;
            m_mode = 0;
          end else begin
            m_mode = 1;
          end
        end
      end
    end
  endtask

  // scoreboard: consume a byte whenever the DUT transfers one
  always @(negedge clk) begin
    if (resetb) begin
      if (overrun) ovr_cnt++;
      if (dout_valid && dout_ready) begin
        rx_cnt++;
        if (exp_q.size() == 0) check_val("unexpected_byte", {31'd0, dout_valid}, 32'd0);
        else check_val("dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic do_reset(input bit check_state);
    resetb     = 1'b0;
    din_valid  = 1'b0;
    din        = 1'b0;
    dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (check_state) begin
      check_val("rst_dout", {24'd0, dout}, 32'h00);
      check_val("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
      check_val("rst_locked", {31'd0, locked}, 32'd0);
      check_val("rst_overrun", {31'd0, overrun}, 32'd0);
    end
    exp_q.delete();
    resetb   = 1'b1;
    enc_prev = 1'b0;
    model_reset();
    rx_cnt  = 0;
    ovr_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic d, input int gap);
    logic line;
`ifdef DIFF_DECODE_RX_NRZI_EN
    line     = d ^ enc_prev;
    enc_prev = line;
`else
    line = d;
`endif
    din       = line;
    din_valid = 1'b1;
    model_step(d);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din       = 1'($urandom_range(0, 1));
    check_val("locked", {31'd0, locked}, (m_mode != 0) ? 32'd1 : 32'd0);
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int gmin, input int gmax);
    for (int i = 7; i >= 0; i--) send_bit(v[i], $urandom_range(gmin, gmax));
  endtask

  task automatic send_nominal(input int gmin, input int gmax);
    send_byte(8'hA5, gmin, gmax);
    send_byte(8'h3C, gmin, gmax);
    send_byte(8'hFF, gmin, gmax);
    send_byte(8'h00, gmin, gmax);
    send_byte(8'h81, gmin, gmax);
    send_byte(8'hA5, gmin, gmax);
  endtask

  task automatic drain(input string tag);
    repeat (4) @(posedge clk);
    #1;
    check_val(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    resetb     = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    enc_prev   = 1'b0;
    model_reset();

    do_reset(1'b1);

    // nominal frame
    send_nominal(0, 0);
    drain("nom_drain");
    check_val("nom_count", rx_cnt, 32'd4);
    check_val("nom_overrun", ovr_cnt, 32'd0);

    // loss of lock: two consecutive bad syncs
    rx_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < FRAME_LEN; k++) send_byte(8'($urandom_range(0, 255)), 0, 0);
      send_byte((f == 0) ? 8'h5A : 8'h00, 0, 0);
      if (f == 0) check_val("lol_first_miss", {31'd0, locked}, 32'd1);
    end
    check_val("lol_unlocked", {31'd0, locked}, 32'd0);
    drain("lol_drain");
    check_val("lol_count", rx_cnt, 32'd8);

    // gapped input
    do_reset(1'b0);
    send_nominal(1, 3);
    drain("gap_drain");
    check_val("gap_count", rx_cnt, 32'd4);

    // backpressure
    do_reset(1'b0);
    push_en    = 1'b0;
    dout_ready = 1'b0;
    send_byte(8'hA5, 0, 0);
    send_byte(8'h3C, 0, 0);
    check_val("bp_valid", {31'd0, dout_valid}, 32'd1);
    check_val("bp_dout", {24'd0, dout}, 32'h3C);
    for (int i = 7; i >= 1; i--) send_bit(1'b1, 0);
    check_val("bp_pre_overrun", {31'd0, overrun}, 32'd0);
    send_bit(1'b1, 0);
    check_val("bp_overrun", {31'd0, overrun}, 32'd1);
    check_val("bp_dout_kept", {24'd0, dout}, 32'h3C);
    @(posedge clk);
    #1;
    check_val("bp_overrun_pulse", {31'd0, overrun}, 32'd0);
    check_val("bp_overrun_cnt", ovr_cnt, 32'd1);
    exp_q.push_back(8'h3C);
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("bp_valid_drop", {31'd0, dout_valid}, 32'd0);
    check_val("bp_drain", exp_q.size(), 32'd0);
    push_en = 1'b1;

    // reset in the middle of payload byte 2
    do_reset(1'b0);
    send_byte(8'hA5, 0, 0);
    send_byte(8'h3C, 0, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    check_val("mr_pre_drain", exp_q.size(), 32'd0);
    resetb = 1'b0;
    #1;
    check_val("mr_valid", {31'd0, dout_valid}, 32'd0);
    check_val("mr_dout", {24'd0, dout}, 32'h00);
    check_val("mr_locked", {31'd0, locked}, 32'd0);
    @(posedge clk);
    #1;
    resetb   = 1'b1;
    enc_prev = 1'b0;
    model_reset();
    rx_cnt = 0;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    send_byte(8'h00, 0, 0);
    send_byte(8'h81, 0, 0);
    check_val("mr_no_output", rx_cnt, 32'd0);
    check_val("mr_still_hunting", {31'd0, locked}, 32'd0);
    send_byte(8'hA5, 0, 0);
    for (int k = 0; k < FRAME_LEN; k++) send_byte(8'($urandom_range(0, 255)), 0, 0);
    drain("mr_drain");
    check_val("mr_count", rx_cnt, 32'd4);

    // random frames with occasional corrupt syncs and random gaps
    do_reset(1'b0);
    for (int i = 0; i < $urandom_range(0, 12); i++) send_bit(1'($urandom_range(0, 1)), 0);
    send_byte(SYNC, 0, 3);
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < FRAME_LEN; k++) send_byte(8'($urandom_range(0, 255)), 0, 3);
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 255)), 0, 3);
      else send_byte(SYNC, 0, 3);
    end
    drain("rnd_drain");
    check_val("rnd_overrun", ovr_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/diff_decode_rx.md
DIFF_DECODE_RX -- requirements
Module: diff_decode_rx

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: frame sync pattern, matched MSB-first.
REQ-002 SHALL have parameter FRAME_LEN, default 4: payload bytes per frame, legal 1..255.
REQ-003 SHALL have parameter MISS_MAX, default 2: consecutive bad sync bytes before loss of lock, legal 1..15.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port resetb  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port din  input  1  encoded serial line bit.
REQ-007 SHALL have port din_valid  input  1  din sampled on this edge when 1.
REQ-008 SHALL have port dout  output  8  decoded payload byte.
REQ-009 SHALL have port dout_valid  output  1  dout holds an unaccepted byte.
REQ-010 SHALL have port dout_ready  input  1  consumer accepts dout when dout_valid=1 on this edge.
REQ-011 SHALL have port locked  output  1  frame alignment held (state != HUNT).
REQ-012 SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped.

Function
REQ-013 SHALL, on an edge with din_valid=0, leave all internal state unchanged; overrun SHALL be 0 on the following cycle.
REQ-014 SHALL decode each valid bit as b = din XOR prev, then update prev <= din (inverse of the line encoder e[n] = d[n] XOR e[n-1]).
REQ-015 SHALL shift b into an 8-bit register MSB-first on every valid bit, in every state.
REQ-016 SHALL implement states HUNT, DATA and CHECK.
REQ-017 SHALL, in HUNT, move to DATA with bit and byte counters cleared on the valid bit completing {shift[6:0], b} == SYNC_BYTE.
REQ-018 SHALL, in DATA, complete a byte every 8th valid bit and present it to the output stage; after FRAME_LEN bytes, move to CHECK.
REQ-019 SHALL, in CHECK, collect 8 valid bits and compare them to SYNC_BYTE.
REQ-020 SHALL, on a CHECK match, clear the miss counter and return to DATA.
REQ-021 SHALL, on a CHECK mismatch, increment the miss counter.
REQ-022 SHALL, after a CHECK mismatch, go to HUNT with the miss counter cleared if the count reaches MISS_MAX, else return to DATA (flywheel).
REQ-023 SHALL not output sync bytes.
REQ-024 SHALL, on re-entering HUNT, detect sync on the very next valid bit if the pattern is present.
REQ-025 SHALL assert dout_valid on the cycle after the edge sampling a byte's 8th bit (latency 1 cycle from last bit).
REQ-026 SHALL hold dout and dout_valid stable until accepted.
REQ-027 SHALL, when a byte completes while dout_valid=1 and dout_ready=0, drop the new byte, keep the old dout, and pulse overrun for one cycle.
REQ-028 SHALL, when a byte completes on the same edge that dout_ready=1 accepts the old byte, load the new byte, keep dout_valid=1, and not assert overrun.
REQ-029 SHALL, on acceptance with no new byte completing, clear dout_valid on the next cycle.
REQ-030 SHALL keep the output stage independent of lock: a held byte stays valid after lock is lost.

Reset
REQ-031 SHALL, while resetb=0, asynchronously force state to HUNT and clear prev, the shift register, all counters, dout (8'h00), dout_valid, locked and overrun.
REQ-032 SHALL, on reset asserted mid-frame, discard any partial byte; after release, reacquire only via a new SYNC_BYTE.

Configuration
REQ-033 SHALL, with DIFF_DECODE_RX_NRZI_EN defined, perform the differential decode of REQ-014.
REQ-034 SHALL, with DIFF_DECODE_RX_NRZI_EN undefined, use b = din directly, omit the prev register, and leave all other behaviour identical.

Verification
REQ-035 SHALL cover nominal decode: encode sync A5 plus payload 3C FF 00 81 plus sync A5, dout_ready=1 -> locked=1 after first sync; dout sequence 3C, FF, 00, 81; overrun never asserted.
REQ-036 SHALL cover loss of lock: lock as in REQ-035, then send 5A and 00 in place of the next two syncs -> locked stays 1 after the first miss and drops to 0 right after the 8th bit of the second miss.
REQ-037 SHALL cover backpressure: hold dout_ready=0 through payload 3C FF -> dout=3C; overrun pulses once at FF completion; after dout_ready=1, dout_valid drops.
REQ-038 SHALL cover gapped input: insert din_valid=0 gaps of 1-3 cycles between every bit of REQ-035 -> identical byte sequence; no spurious dout_valid.
REQ-039 SHALL cover mid-frame reset: pulse resetb=0 after 3 bits of payload byte 2 -> immediately dout_valid=0, dout=00, locked=0; the following payload yields no output until a new A5.
REQ-040 SHALL cover the macro-undefined build: feed raw (unencoded) bits A5 3C -> dout=3C.
